uvmt_obi_st_rr_arbiter: RTL and testbench
=========================================

// Module: uvmt_obi_st_rr_arbiter
// PURPOSE
//  Shares one OBI slave port among NUM_MSTRS OBI master ports.
//  A channel: round-robin arbitration with address-phase lock.
//  R channel: in-order routing of responses via an ordering FIFO holding the granted master index.
//  Sits between master-side agents/DUTs and a single slave, replacing the 1:1 master/slave wiring.
// PARAMETERS
//  NUM_MSTRS        4   number of master ports (>=2)
//  ADDR_WIDTH      32   address width
//  DATA_WIDTH      32   data width; be width = DATA_WIDTH/8
//  MAX_OUTSTANDING  4   max granted-but-unanswered transactions (ordering FIFO depth, >=1)
// PORTS
//  clk          in   1                  clock, all logic on rising edge
//  reset_n      in   1                  synchronous active-low reset
//  m_req        in   NUM_MSTRS          per-master request
//  m_gnt        out  NUM_MSTRS          per-master grant
//  m_addr       in   NUM_MSTRS*AW       packed per-master address
//  m_we         in   NUM_MSTRS          per-master write enable
//  m_be         in   NUM_MSTRS*DW/8     per-master byte enables
//  m_wdata      in   NUM_MSTRS*DW       per-master write data
//  m_rvalid     out  NUM_MSTRS          per-master response valid
//  m_rready     in   NUM_MSTRS          per-master response ready
//  m_rdata      out  DW                 response data, broadcast to all masters
//  m_err        out  1                  response error, broadcast
//  s_req/s_addr/s_we/s_be/s_wdata  out  slave A channel (widths as single master)
//  s_gnt        in   1                  slave grant
//  s_rvalid     in   1                  slave response valid
//  s_rready     out  1                  slave response ready
//  s_rdata      in   DW ; s_err  in  1  slave response
//  outstanding  out  $clog2(MAX_OUTSTANDING+1)  ordering FIFO occupancy
//  proto_err    out  1                  sticky: s_rvalid seen with empty FIFO
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): rr pointer=0, lock=0, FIFO empty, outstanding=0, proto_err=0.
//   While reset_n=0: s_req, m_gnt, m_rvalid, s_rready are forced 0. Transactions in flight at reset are discarded.
//  can_issue = (outstanding < MAX_OUTSTANDING). A pop in the same cycle does NOT free a slot.
//  Arbitration (combinational, zero latency):
//   - If lock=0: sel = first m_req[i] set, scanning from rr pointer upward with wrap. Otherwise sel = locked_idx.
//   - s_req = can_issue & (lock | |m_req); s_addr/we/be/wdata muxed from sel.
//   - m_gnt[sel] = s_req & s_gnt; all other m_gnt = 0.
//  Lock FSM: IDLE -> HOLD when s_req & !s_gnt (locked_idx <= sel); HOLD -> IDLE on s_gnt.
//   Held request is never re-arbitrated, keeping OBI address-phase stability.
//  On A handshake (s_req & s_gnt): push sel into FIFO; rr pointer <= (sel+1) mod NUM_MSTRS.
//  R channel (combinational): head = FIFO head index.
//   - m_rvalid[head] = s_rvalid & !empty; s_rready = m_rready[head] & !empty.
//   - m_rdata = s_rdata; m_err = s_err.
//   - Pop when s_rvalid & s_rready.
//  Simultaneous push+pop: occupancy unchanged, FIFO pointers wrap mod MAX_OUTSTANDING.
//  s_rvalid with empty FIFO: s_rready=0, proto_err <= 1 (held until reset).
//  Latency: 0 cycles on A and R paths; no throughput bubble while can_issue.
// STRUCTURE
//  uvmt_obi_st_arb_pkg: localparam IDX_W=$clog2(NUM_MSTRS), typedef idx_t, typedef lock_state_e {IDLE,HOLD}.
//  Sub-module uvmt_obi_st_arb_fifo: sync FIFO of idx_t (push/pop/full/empty/count); reset as above.
//  Top: rr priority scan, lock FSM, A-channel mux, R-channel demux.
// TESTING
//  1 m_req=4'b1111 held, s_gnt=1 every cycle -> grants in order 0,1,2,3,0; one per cycle.
//  2 m_req=4'b0110, s_gnt low 3 cycles -> s_req and s_addr=m_addr[1] stable for 3 cycles, m_gnt[1] then m_gnt[2].
//  3 Slave never sends rvalid; 5 requests -> 4 granted, outstanding=4, s_req=0; rvalid pops 1 -> next grant the following cycle.
//  4 Grants to m2,m0,m3, rvalid each cycle -> m_rvalid pulses on 4'b0100, 4'b0001, 4'b1000 in that order, with rdata/err as sent.
//  5 s_rvalid=1 at reset exit with FIFO empty -> proto_err=1 next cycle, m_rvalid=0, s_rready=0.
//  6 reset_n=0 with outstanding=3 -> next cycle outstanding=0, pointer=0, and the next request from m_req=4'b1000 is granted to m3.

Source files
------------

// File: rtl/uvmt_obi_st_arb_pkg.sv
// Shared types and helpers for the OBI single-slave round-robin arbiter.
//   DFLT_NUM_MSTRS / IDX_W / idx_t : default master count and index type
//   lock_state_e                    : address-phase lock FSM states
//   idx_w_of()                      : index width that never collapses to 0 bits
package uvmt_obi_st_arb_pkg;

  localparam int DFLT_NUM_MSTRS = 4;
  localparam int IDX_W          = $clog2(DFLT_NUM_MSTRS);

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } lock_state_e;

  // Width of an index/pointer into n entries; a single entry still gets 1 bit.
  function automatic int idx_w_of(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uvmt_obi_st_rr_arbiter_if.sv
// Bundle of all OBI handshake signals around the arbiter.
//   m_* : NUM_MSTRS master-side ports (packed per master, master 0 in the LSBs)
//   s_* : the single shared slave port
// Modports:
//   master : the arbiter itself (it masters the shared slave port)
//   slave  : the surrounding agents (drive m_* requests and the slave responses)
// Handshake rules: an A-channel transfer happens in a cycle where req & gnt are
// both high, and req plus its address-phase payload must stay stable until then;
// an R-channel transfer happens in a cycle where rvalid & rready are both high.
interface uvmt_obi_st_rr_arbiter_if #(
  parameter int NUM_MSTRS  = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;

  logic [NUM_MSTRS-1:0]            m_req;
  logic [NUM_MSTRS-1:0]            m_gnt;
  logic [NUM_MSTRS*ADDR_WIDTH-1:0] m_addr;
  logic [NUM_MSTRS-1:0]            m_we;
  logic [NUM_MSTRS*BW-1:0]         m_be;
  logic [NUM_MSTRS*DATA_WIDTH-1:0] m_wdata;
  logic [NUM_MSTRS-1:0]            m_rvalid;
  logic [NUM_MSTRS-1:0]            m_rready;
  logic [DATA_WIDTH-1:0]           m_rdata;
  logic                            m_err;

  logic                            s_req;
  logic                            s_gnt;
  logic [ADDR_WIDTH-1:0]           s_addr;
  logic                            s_we;
  logic [BW-1:0]                   s_be;
  logic [DATA_WIDTH-1:0]           s_wdata;
  logic                            s_rvalid;
  logic                            s_rready;
  logic [DATA_WIDTH-1:0]           s_rdata;
  logic                            s_err;

  modport master (
    input  m_req, m_addr, m_we, m_be, m_wdata, m_rready,
    output m_gnt, m_rvalid, m_rdata, m_err,
    output s_req, s_addr, s_we, s_be, s_wdata, s_rready,
    input  s_gnt, s_rvalid, s_rdata, s_err
  );

  modport slave (
    output m_req, m_addr, m_we, m_be, m_wdata, m_rready,
    input  m_gnt, m_rvalid, m_rdata, m_err,
    input  s_req, s_addr, s_we, s_be, s_wdata, s_rready,
    output s_gnt, s_rvalid, s_rdata, s_err
  );

endinterface

// File: rtl/uvmt_obi_st_arb_fifo.sv
// Ordering FIFO: remembers which master owns each granted-but-unanswered
// transaction, oldest at the head.
//   clk, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, din    : enqueue din (ignored when full)
//   pop          : dequeue head (ignored when empty)
//   dout         : head entry, valid while !empty
//   full, empty  : status flags
//   count        : occupancy 0..DEPTH
module uvmt_obi_st_arb_fifo
  import uvmt_obi_st_arb_pkg::*;
#(
  parameter int W     = IDX_W,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = idx_w_of(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_ok;
  logic          pop_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_next(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uvmt_obi_st_rr_arbiter.sv
// Shares one OBI slave port among NUM_MSTRS OBI master ports.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : all master-side and slave-side OBI signals (modport master)
//   outstanding  : granted-but-unanswered transaction count
//   proto_err    : sticky, slave sent a response with nothing outstanding
//   rr_ptr       : round-robin starting point for the next arbitration (debug)
//   lock_state   : address-phase lock FSM state (debug)
// A channel: round-robin pick, locked onto the chosen master until the slave
// grants so the address phase never changes under a pending request.
// R channel: responses come back in order and are routed to the master index at
// the head of the ordering FIFO.
module uvmt_obi_st_rr_arbiter
  import uvmt_obi_st_arb_pkg::*;
#(
  parameter int  NUM_MSTRS       = 4,
  parameter int  ADDR_WIDTH      = 32,
  parameter int  DATA_WIDTH      = 32,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1),
  localparam int IW              = idx_w_of(NUM_MSTRS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  uvmt_obi_st_rr_arbiter_if.master  bus,
  output logic [CW-1:0]             outstanding,
  output logic                      proto_err,
  output logic [IW-1:0]             rr_ptr,
  output lock_state_e               lock_state
);

  localparam int BW = DATA_WIDTH / 8;

  lock_state_e   state_q, state_d;
  logic [IW-1:0] locked_idx_q, locked_idx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          proto_err_q;

  logic [IW-1:0] scan_idx;
  logic [IW-1:0] sel;
  logic [IW-1:0] head_idx;
  logic          any_req;
  logic          can_issue;
  logic          handshake;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [CW-1:0] fifo_count;

  // Round-robin scan: first requester at or above rr_ptr, wrapping around.
  always_comb begin
    int   j;
    logic found;
    scan_idx = rr_ptr_q;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < NUM_MSTRS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_MSTRS) j = j - NUM_MSTRS;
      if (!found && bus.m_req[j]) begin
        scan_idx = IW'(j);
        found    = 1'b1;
      end
    end
  end

  assign any_req = |bus.m_req;
  // A slot freed by a pop only becomes usable the following cycle.
  assign can_issue = ~fifo_full;
  assign sel = (state_q == HOLD) ? locked_idx_q : scan_idx;

  // A-channel mux
  assign bus.s_req   = reset_n & can_issue & ((state_q == HOLD) | any_req);
  assign bus.s_addr  = bus.m_addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign bus.s_we    = bus.m_we[sel];
  assign bus.s_be    = bus.m_be[int'(sel)*BW +: BW];
  assign bus.s_wdata = bus.m_wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign handshake   = bus.s_req & bus.s_gnt;

  always_comb begin
    bus.m_gnt = '0;
    if (handshake) bus.m_gnt[sel] = 1'b1;
  end

  // Lock FSM and round-robin pointer update
  always_comb begin
    state_d      = state_q;
    locked_idx_d = locked_idx_q;
    rr_ptr_d     = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.s_req && !bus.s_gnt) begin
          state_d      = HOLD;
          locked_idx_d = sel;
        end
      end
      HOLD: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (handshake) rr_ptr_d = (int'(sel) == NUM_MSTRS - 1) ? '0 : sel + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      locked_idx_q <= '0;
      rr_ptr_q     <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked_idx_q <= locked_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      if (bus.s_rvalid && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  uvmt_obi_st_arb_fifo #(
    .W     (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (handshake),
    .din     (sel),
    .pop     (pop),
    .dout    (head_idx),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // R-channel demux: only the owner of the oldest transaction sees rvalid.
  always_comb begin
    bus.m_rvalid = '0;
    if (reset_n && bus.s_rvalid && !fifo_empty) bus.m_rvalid[head_idx] = 1'b1;
  end

  assign bus.s_rready = reset_n & ~fifo_empty & bus.m_rready[head_idx];
  assign pop          = bus.s_rvalid & bus.s_rready;
  assign bus.m_rdata  = bus.s_rdata;
  assign bus.m_err    = bus.s_err;

  assign outstanding = fifo_count;
  assign proto_err   = proto_err_q;
  assign rr_ptr      = rr_ptr_q;
  assign lock_state  = state_q;

endmodule

// File: tb/tb_uvmt_obi_st_rr_arbiter.sv
module tb_uvmt_obi_st_rr_arbiter;
  import uvmt_obi_st_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;
  localparam int BW = DW / 8;
  localparam int CW = $clog2(MO + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CW-1:0] outstanding;
  logic          proto_err;
  logic [1:0]    rr_ptr;
  lock_state_e   lock_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] exp_v;

  uvmt_obi_st_rr_arbiter_if #(.NUM_MSTRS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  uvmt_obi_st_rr_arbiter #(
    .NUM_MSTRS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .outstanding (outstanding),
    .proto_err   (proto_err),
    .rr_ptr      (rr_ptr),
    .lock_state  (lock_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int i);
    return AW'(32'hA000_0000 + i * 16);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.m_req    = '0;
    bus.m_rready = '1;
    bus.s_gnt    = 1'b0;
    bus.s_rvalid = 1'b0;
    bus.s_rdata  = '0;
    bus.s_err    = 1'b0;
  endtask

  task automatic load_payloads();
    for (int i = 0; i < N; i++) begin
      bus.m_addr[i*AW +: AW]  = addr_of(i);
      bus.m_wdata[i*DW +: DW] = DW'(32'hD000_0000 + i);
      bus.m_be[i*BW +: BW]    = BW'(i + 1);
      bus.m_we[i]             = i[0];
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    load_payloads();

    // reset: outputs forced low even with requests present
    bus.m_req = 4'b1111;
    bus.s_gnt = 1'b1;
    settle();
    chk("rst_s_req", 64'(bus.s_req), 64'd0);
    chk("rst_m_gnt", 64'(bus.m_gnt), 64'd0);
    tick();
    tick();
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_rr_ptr", 64'(rr_ptr), 64'd0);
    chk("rst_lock", 64'(lock_state), 64'(IDLE));
    reset_n = 1'b1;

    // 1: all request, slave always grants -> 0,1,2,3,0; responses one cycle behind
    for (int k = 0; k < 5; k++) begin
      bus.m_req    = 4'b1111;
      bus.s_gnt    = 1'b1;
      bus.s_rvalid = (k > 0);
      settle();
      chk($sformatf("t1_gnt%0d", k), 64'(bus.m_gnt), 64'(4'b0001 << (k % 4)));
      if (k == 0) chk("t1_addr0", 64'(bus.s_addr), 64'(addr_of(0)));
      if (k > 0) chk($sformatf("t1_rvalid%0d", k), 64'(bus.m_rvalid), 64'(4'b0001 << ((k - 1) % 4)));
      tick();
    end
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    bus.s_rvalid = 1'b1;
    settle();
    chk("t1_rvalid_last", 64'(bus.m_rvalid), 64'(4'b0001));
    tick();
    bus.s_rvalid = 1'b0;
    settle();
    chk("t1_outstanding", 64'(outstanding), 64'd0);
    chk("t1_rr_ptr", 64'(rr_ptr), 64'd1);

    // 2: stalled slave keeps request and address stable on m1, then m1, m2
    bus.m_req = 4'b0110;
    bus.s_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk($sformatf("t2_s_req%0d", c), 64'(bus.s_req), 64'd1);
      chk($sformatf("t2_addr%0d", c), 64'(bus.s_addr), 64'(addr_of(1)));
      chk($sformatf("t2_gnt%0d", c), 64'(bus.m_gnt), 64'd0);
      if (c > 0) chk($sformatf("t2_lock%0d", c), 64'(lock_state), 64'(HOLD));
      tick();
    end
    bus.s_gnt = 1'b1;
    settle();
    chk("t2_gnt_m1", 64'(bus.m_gnt), 64'(4'b0010));
    chk("t2_be_m1", 64'(bus.s_be), 64'd2);
    tick();
    settle();
    chk("t2_gnt_m2", 64'(bus.m_gnt), 64'(4'b0100));
    chk("t2_addr_m2", 64'(bus.s_addr), 64'(addr_of(2)));
    tick();
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    settle();
    chk("t2_outstanding", 64'(outstanding), 64'd2);
    bus.s_rvalid = 1'b1;
    bus.s_rdata  = 32'h1234_5678;
    settle();
    chk("t2_rvalid_m1", 64'(bus.m_rvalid), 64'(4'b0010));
    chk("t2_rdata", 64'(bus.m_rdata), 64'(32'h1234_5678));
    tick();
    bus.s_err = 1'b1;
    settle();
    chk("t2_rvalid_m2", 64'(bus.m_rvalid), 64'(4'b0100));
    chk("t2_err", 64'(bus.m_err), 64'd1);
    tick();
    idle_inputs();
    settle();
    chk("t2_drained", 64'(outstanding), 64'd0);

    // 3: slave withholds responses -> four grants, then stall at MAX_OUTSTANDING
    bus.m_req = 4'b1111;
    bus.s_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t3_gnt%0d", c), 64'(bus.m_gnt), 64'(4'b0001 << ((3 + c) % 4)));
      tick();
    end
    settle();
    chk("t3_full_s_req", 64'(bus.s_req), 64'd0);
    chk("t3_full_gnt", 64'(bus.m_gnt), 64'd0);
    chk("t3_full_cnt", 64'(outstanding), 64'd4);
    tick();
    bus.s_rvalid = 1'b1;
    settle();
    chk("t3_pop_rvalid", 64'(bus.m_rvalid), 64'(4'b1000));
    chk("t3_pop_no_free", 64'(bus.s_req), 64'd0);
    tick();
    bus.s_rvalid = 1'b0;
    settle();
    chk("t3_after_pop_cnt", 64'(outstanding), 64'd3);
    chk("t3_next_gnt", 64'(bus.m_gnt), 64'(4'b1000));
    tick();
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    bus.s_rvalid = 1'b1;
    bus.m_rready = '0;
    settle();
    chk("t3_bp_rvalid", 64'(bus.m_rvalid), 64'(4'b0001));
    chk("t3_bp_s_rready", 64'(bus.s_rready), 64'd0);
    tick();
    chk("t3_bp_cnt", 64'(outstanding), 64'd4);
    bus.m_rready = '1;
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("t3_drain%0d", c), 64'(bus.m_rvalid), 64'(4'b0001 << c));
      tick();
    end
    bus.s_rvalid = 1'b0;
    settle();
    chk("t3_drained", 64'(outstanding), 64'd0);

    // 4: grants to m2, m0, m3 -> responses routed in that order
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       exp_v = 4'b0100;
        1:       exp_v = 4'b0001;
        default: exp_v = 4'b1000;
      endcase
      bus.m_req = exp_v;
      bus.s_gnt = 1'b1;
      settle();
      chk($sformatf("t4_gnt%0d", i), 64'(bus.m_gnt), 64'(exp_v));
      exp_q.push_back(exp_v);
      tick();
    end
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = DW'(32'hCAFE_0000 + i);
      bus.s_err    = i[0];
      settle();
      chk($sformatf("t4_rvalid%0d", i), 64'(bus.m_rvalid), 64'(exp_q.pop_front()));
      chk($sformatf("t4_rdata%0d", i), 64'(bus.m_rdata), 64'(32'hCAFE_0000 + i));
      chk($sformatf("t4_err%0d", i), 64'(bus.m_err), 64'(i[0]));
      tick();
    end
    idle_inputs();

    // 5: response with nothing outstanding at reset exit
    reset_n = 1'b0;
    bus.s_rvalid = 1'b1;
    tick();
    chk("t5_rst_proto", 64'(proto_err), 64'd0);
    reset_n = 1'b1;
    settle();
    chk("t5_m_rvalid", 64'(bus.m_rvalid), 64'd0);
    chk("t5_s_rready", 64'(bus.s_rready), 64'd0);
    tick();
    chk("t5_proto_set", 64'(proto_err), 64'd1);
    bus.s_rvalid = 1'b0;
    tick();
    chk("t5_proto_sticky", 64'(proto_err), 64'd1);

    // 6: reset with three outstanding discards them and the pointer
    bus.m_req = 4'b1111;
    bus.s_gnt = 1'b1;
    tick();
    tick();
    tick();
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    settle();
    chk("t6_cnt3", 64'(outstanding), 64'd3);
    chk("t6_ptr3", 64'(rr_ptr), 64'd3);
    reset_n = 1'b0;
    bus.m_req = 4'b1111;
    bus.s_gnt = 1'b1;
    settle();
    chk("t6_rst_s_req", 64'(bus.s_req), 64'd0);
    chk("t6_rst_gnt", 64'(bus.m_gnt), 64'd0);
    tick();
    chk("t6_cnt0", 64'(outstanding), 64'd0);
    chk("t6_ptr0", 64'(rr_ptr), 64'd0);
    chk("t6_proto_clr", 64'(proto_err), 64'd0);
    reset_n = 1'b1;
    bus.m_req = 4'b1000;
    settle();
    chk("t6_gnt_m3", 64'(bus.m_gnt), 64'(4'b1000));
    tick();
    bus.m_req = '0;
    bus.s_gnt = 1'b0;
    bus.s_rvalid = 1'b1;
    settle();
    chk("t6_rvalid_m3", 64'(bus.m_rvalid), 64'(4'b1000));
    tick();
    bus.s_rvalid = 1'b0;
    settle();
    chk("t6_drained", 64'(outstanding), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
